// File: rtl/pc_fetch_ctrl.sv
// Fetch PC sequencer: boot, sequential increment, redirect/trap steering,
// and buffering of one redirect while the downstream PC register is stalled.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  input  logic        trap,
  output logic [31:0] pc_out,
  output logic        fetch_valid,
  output logic        misalign,
  output logic [31:0] misalign_addr,
  output logic        pend_valid
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_trap_q, pend_trap_d;
  logic        pend_mis_q, pend_mis_d;
  logic [31:0] pend_mis_addr_q, pend_mis_addr_d;
  logic        misalign_q, misalign_d;
  logic [31:0] misalign_addr_q, misalign_addr_d;

  // Resolved request presented this cycle (trap beats redirect).
  logic        new_req;
  logic        new_mis;
  logic [31:0] new_tgt;

  always_comb begin
    new_req = trap | redir_valid;
    new_mis = ~trap & redir_valid & (redir_target[1:0] != 2'b00);
    if (trap || new_mis) new_tgt = TRAP_VEC;
    else                 new_tgt = redir_target;
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pend_pc_d       = pend_pc_q;
    pend_trap_d     = pend_trap_q;
    pend_mis_d      = pend_mis_q;
    pend_mis_addr_d = pend_mis_addr_q;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;

    unique case (state_q)
      BOOT: begin
        pc_d    = RESET_PC;
        state_d = RUN;
      end
      RUN: begin
        if (!stall) begin
          if (new_req) pc_d = new_tgt;
          else         pc_d = pc_q + 32'd4;
          if (new_mis) begin
            misalign_d      = 1'b1;
            misalign_addr_d = redir_target;
          end
        end else if (new_req) begin
          pend_pc_d       = new_tgt;
          pend_trap_d     = trap;
          pend_mis_d      = new_mis;
          pend_mis_addr_d = redir_target;
          state_d         = PEND;
        end
      end
      PEND: begin
        if (stall) begin
          // A buffered trap cannot be displaced by a later redirect.
          if (trap) begin
            pend_pc_d   = TRAP_VEC;
            pend_trap_d = 1'b1;
            pend_mis_d  = 1'b0;
          end else if (redir_valid && !pend_trap_q) begin
            pend_pc_d       = new_tgt;
            pend_mis_d      = new_mis;
            pend_mis_addr_d = redir_target;
          end
        end else begin
          if (new_req) begin
            pc_d = new_tgt;
            if (new_mis) begin
              misalign_d      = 1'b1;
              misalign_addr_d = redir_target;
            end
          end else begin
            pc_d = pend_pc_q;
            if (pend_mis_q) begin
              misalign_d      = 1'b1;
              misalign_addr_d = pend_mis_addr_q;
            end
          end
          pend_pc_d       = 32'd0;
          pend_trap_d     = 1'b0;
          pend_mis_d      = 1'b0;
          pend_mis_addr_d = 32'd0;
          state_d         = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= BOOT;
      pc_q            <= RESET_PC;
      pend_pc_q       <= 32'd0;
      pend_trap_q     <= 1'b0;
      pend_mis_q      <= 1'b0;
      pend_mis_addr_q <= 32'd0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pend_pc_q       <= pend_pc_d;
      pend_trap_q     <= pend_trap_d;
      pend_mis_q      <= pend_mis_d;
      pend_mis_addr_q <= pend_mis_addr_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign pc_out        = pc_q;
  assign fetch_valid   = (state_q == RUN) || (state_q == PEND);
  assign pend_valid    = (state_q == PEND);
  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;

endmodule
